// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM
// shared-SRAM arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INST = 2'd1,
    S_DATA = 2'd2
  } arb_state_e;

  localparam logic MEM_READ  = 1'b0;
  localparam logic MEM_WRITE = 1'b1;

  localparam logic [15:0] INST_NOP_DEF = 16'h0800;
  localparam int          WAIT_MAX     = 15;

endpackage

// File: rtl/mem_arbiter_if.sv
// Client and SRAM-side signal bundle of the
// shared memory arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W = 18,
  parameter int DATA_W = 16
);

  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic [DATA_W-1:0] if_rdata_o;
  logic              if_valid_o;

  logic              dm_rd_i;
  logic              dm_wr_i;
  logic [ADDR_W-1:0] dm_addr_i;
  logic [DATA_W-1:0] dm_wdata_i;
  logic [DATA_W-1:0] dm_rdata_o;
  logic              dm_done_o;

  logic              stall_o;
  logic              proto_err_o;

  logic              mem_en_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  modport slave (
    input  if_req_i, if_addr_i,
    output if_rdata_o, if_valid_o,
    input  dm_rd_i, dm_wr_i,
    input  dm_addr_i, dm_wdata_i,
    output dm_rdata_o, dm_done_o,
    output stall_o, proto_err_o,
    output mem_en_o, mem_we_o,
    output mem_addr_o, mem_wdata_o,
    input  mem_rdata_i
  );

  modport master (
    output if_req_i, if_addr_i,
    input  if_rdata_o, if_valid_o,
    output dm_rd_i, dm_wr_i,
    output dm_addr_i, dm_wdata_i,
    input  dm_rdata_o, dm_done_o,
    input  stall_o, proto_err_o,
    input  mem_en_o, mem_we_o,
    input  mem_addr_o, mem_wdata_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/mem_wait_timer.sv
// Loadable down-counter; o_last marks the final
// cycle of a WAIT_CYCLES-long SRAM access.
module mem_wait_timer
  import mem_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_last
);

  if (WAIT_CYCLES < 1 ||
      WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("WAIT_CYCLES out of range 1..15");
  end

  logic [3:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= 4'(WAIT_CYCLES - 1);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IF fetches and MEM data accesses onto
// one SRAM port; data first, fetches never starved.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 1,
  parameter logic [DATA_W-1:0] INST_NOP =
    DATA_W'(INST_NOP_DEF)
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic              r_last_data;
  logic              r_en;
  logic              r_we;
  logic              r_if_valid;
  logic              r_dm_done;
  logic              r_proto_err;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_dm_rdata;

  logic w_tmr_last;
  logic w_last;
  logic w_arb;
  logic w_dm_vld;
  logic w_dm_ok;
  logic w_if_ok;
  logic w_sel_dm;
  logic w_sel_if;
  logic w_pick_dm;
  logic w_pick_if;
  logic w_grant;

  assign w_dm_vld = bus.dm_rd_i ^ bus.dm_wr_i;
  assign w_last   = (r_state != S_IDLE) & w_tmr_last;
  assign w_arb    = (r_state == S_IDLE) | w_last;

  // the client being served still holds its level
  assign w_dm_ok  = w_dm_vld & ~r_dm_done &
                    (r_state != S_DATA);
  assign w_if_ok  = bus.if_req_i & ~r_if_valid &
                    (r_state != S_INST);
  assign w_sel_dm = w_dm_ok &
                    (~r_last_data | ~w_if_ok);
  assign w_sel_if = w_if_ok & ~w_sel_dm;
  assign w_grant  = w_pick_dm | w_pick_if;

  mem_wait_timer #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_grant),
    .o_last (w_tmr_last)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pick_dm   = 1'b0;
    w_pick_if   = 1'b0;
    if (w_arb) begin
      unique case (1'b1)
        w_sel_dm: begin
          w_state_nxt = S_DATA;
          w_pick_dm   = 1'b1;
        end
        w_sel_if: begin
          w_state_nxt = S_INST;
          w_pick_if   = 1'b1;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_data <= 1'b0;
      r_en        <= 1'b0;
      r_we        <= MEM_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= INST_NOP;
      r_dm_rdata  <= '0;
      r_if_valid  <= 1'b0;
      r_dm_done   <= 1'b0;
      r_proto_err <= 1'b0;
    end else begin
      r_if_valid  <= w_last & (r_state == S_INST);
      r_dm_done   <= w_last & (r_state == S_DATA);
      r_proto_err <= bus.dm_rd_i & bus.dm_wr_i;
      if (w_last & (r_state == S_INST))
        r_if_rdata <= bus.mem_rdata_i;
      if (w_last & (r_state == S_DATA) &
          (r_we == MEM_READ))
        r_dm_rdata <= bus.mem_rdata_i;
      if (w_grant) begin
        r_en        <= 1'b1;
        r_last_data <= w_pick_dm;
        r_we        <= (w_pick_dm & bus.dm_wr_i) ?
                       MEM_WRITE : MEM_READ;
        r_addr      <= w_pick_dm ? bus.dm_addr_i :
                                   bus.if_addr_i;
        if (w_pick_dm) r_wdata <= bus.dm_wdata_i;
      end else if (w_last) begin
        r_en <= 1'b0;
        r_we <= MEM_READ;
      end
    end
  end

  assign bus.if_rdata_o  = r_if_rdata;
  assign bus.if_valid_o  = r_if_valid;
  assign bus.dm_rdata_o  = r_dm_rdata;
  assign bus.dm_done_o   = r_dm_done;
  assign bus.proto_err_o = r_proto_err;
  assign bus.mem_en_o    = r_en;
  assign bus.mem_we_o    = r_we;
  assign bus.mem_addr_o  = r_addr;
  assign bus.mem_wdata_o = r_wdata;
  assign bus.stall_o     =
    (w_dm_vld & ~r_dm_done) |
    (bus.if_req_i & ~r_if_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
// Random and directed checks of mem_arbiter against
// a transaction-level reference model.
module tb_mem_arbiter;

  localparam int W = 2;

  logic clk;
  logic rst;

  mem_arbiter_if #(.ADDR_W(18), .DATA_W(16)) bus();

  mem_arbiter #(
    .ADDR_W      (18),
    .DATA_W      (16),
    .WAIT_CYCLES (W),
    .INST_NOP    (16'h0800)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag,
                     logic [31:0] got,
                     logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  // model: who owns the port and how many
  // enable cycles are left in its access
  int          m_busy;
  int          m_left;
  bit          m_last_data;
  bit          m_en, m_we;
  bit          m_ifv, m_dmd, m_perr;
  logic [17:0] m_addr;
  logic [15:0] m_wdata, m_ifr, m_dmr;

  task automatic model_reset();
    m_busy = 0; m_left = 0; m_last_data = 0;
    m_en = 0; m_we = 0; m_addr = '0;
    m_wdata = '0; m_ifr = 16'h0800;
    m_dmr = '0; m_ifv = 0; m_dmd = 0;
    m_perr = 0;
  endtask

  task automatic model_step();
    bit fin, dmw, ifw, take_dm;
    if (rst) begin
      model_reset();
      return;
    end
    fin = (m_busy != 0) && (m_left == 1);
    dmw = (bus.dm_rd_i != bus.dm_wr_i) &&
          !m_dmd && (m_busy != 2);
    ifw = bus.if_req_i && !m_ifv &&
          (m_busy != 1);
    m_perr = bus.dm_rd_i && bus.dm_wr_i;
    m_ifv  = fin && (m_busy == 1);
    m_dmd  = fin && (m_busy == 2);
    if (m_ifv) m_ifr = bus.mem_rdata_i;
    if (m_dmd && !m_we) m_dmr = bus.mem_rdata_i;
    if (m_busy == 0 || fin) begin
      take_dm = dmw && (!m_last_data || !ifw);
      if (take_dm) begin
        m_busy = 2; m_left = W; m_en = 1;
        m_we = bus.dm_wr_i;
        m_addr = bus.dm_addr_i;
        m_wdata = bus.dm_wdata_i;
        m_last_data = 1;
      end else if (ifw) begin
        m_busy = 1; m_left = W; m_en = 1;
        m_we = 0; m_addr = bus.if_addr_i;
        m_last_data = 0;
      end else begin
        m_busy = 0; m_left = 0;
        m_en = 0; m_we = 0;
      end
    end else begin
      m_left--;
    end
  endtask

  task automatic compare();
    bit st;
    st = ((bus.dm_rd_i ^ bus.dm_wr_i) & ~m_dmd) |
         (bus.if_req_i & ~m_ifv);
    chk("en", 32'(bus.mem_en_o), 32'(m_en));
    chk("we", 32'(bus.mem_we_o), 32'(m_we));
    chk("addr", 32'(bus.mem_addr_o), 32'(m_addr));
    chk("wdata", 32'(bus.mem_wdata_o),
        32'(m_wdata));
    chk("if_rdata", 32'(bus.if_rdata_o),
        32'(m_ifr));
    chk("dm_rdata", 32'(bus.dm_rdata_o),
        32'(m_dmr));
    chk("if_valid", 32'(bus.if_valid_o),
        32'(m_ifv));
    chk("dm_done", 32'(bus.dm_done_o), 32'(m_dmd));
    chk("perr", 32'(bus.proto_err_o), 32'(m_perr));
    chk("stall", 32'(bus.stall_o), 32'(st));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    bus.if_req_i = 0; bus.dm_rd_i = 0;
    bus.dm_wr_i = 0;
  endtask

  task automatic dm_new_op();
    bit kind;
    kind = bit'($urandom_range(1));
    bus.dm_wr_i = kind;
    bus.dm_rd_i = !kind;
    bus.dm_addr_i = 18'($urandom);
    bus.dm_wdata_i = 16'($urandom);
  endtask

  int  cnt, t_dm, t_if, t0, prev, npulse;
  bit  seen, alt_ok, perr_now;
  logic [17:0] first_addr;

  initial begin
    model_reset();
    rst = 1;
    idle_inputs();
    bus.if_addr_i = '0; bus.dm_addr_i = '0;
    bus.dm_wdata_i = '0; bus.mem_rdata_i = '0;

    // reset state
    repeat (3) cyc();
    chk("rst_nop", 32'(bus.if_rdata_o), 32'h0800);
    chk("rst_en", 32'(bus.mem_en_o), 0);
    chk("rst_pulses", 32'({bus.if_valid_o,
        bus.dm_done_o, bus.proto_err_o}), 0);

    // first fetch out of reset
    rst = 0; bus.if_req_i = 1;
    bus.if_addr_i = 18'h00010;
    bus.mem_rdata_i = 16'h1234;
    cnt = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      if (bus.mem_en_o) cnt++;
      if (bus.if_valid_o) seen = 1;
    end
    bus.if_req_i = 0;
    chk("fetch_done", 32'(seen), 1);
    chk("fetch_en_cyc", 32'(cnt), 32'(W));
    chk("fetch_data", 32'(bus.if_rdata_o),
        32'h1234);

    // write
    bus.dm_wr_i = 1; bus.dm_addr_i = 18'h3F000;
    bus.dm_wdata_i = 16'hBEEF;
    cnt = 0; seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      if (bus.mem_en_o && bus.mem_we_o &&
          bus.mem_wdata_o == 16'hBEEF) cnt++;
      if (bus.dm_done_o) seen = 1;
    end
    bus.dm_wr_i = 0;
    chk("wr_done", 32'(seen), 1);
    chk("wr_cycles", 32'(cnt), 32'(W));
    chk("wr_rdata_keep", 32'(bus.dm_rdata_o), 0);

    // protocol error
    cyc();
    bus.dm_rd_i = 1; bus.dm_wr_i = 1;
    cyc();
    bus.dm_rd_i = 0; bus.dm_wr_i = 0;
    chk("perr_pulse", 32'(bus.proto_err_o), 1);
    chk("perr_no_en", 32'(bus.mem_en_o), 0);
    cyc();
    chk("perr_clear", 32'(bus.proto_err_o), 0);
    chk("perr_we", 32'(bus.mem_we_o), 0);
    chk("perr_en", 32'(bus.mem_en_o), 0);

    // fetch alone so that last grant was INST
    bus.if_req_i = 1; bus.if_addr_i = 18'h00020;
    seen = 0;
    for (int i = 0; i < 12 && !seen; i++) begin
      cyc();
      if (bus.if_valid_o) seen = 1;
    end
    bus.if_req_i = 0;
    chk("pre_fetch", 32'(seen), 1);
    cyc();

    // contention: data first, then fetch
    bus.if_req_i = 1; bus.if_addr_i = 18'h00030;
    bus.dm_rd_i = 1; bus.dm_addr_i = 18'h00040;
    bus.mem_rdata_i = 16'h5A5A;
    t_dm = -1; t_if = -1; first_addr = '1;
    for (int i = 1; i < 20 && t_if < 0; i++) begin
      cyc();
      if (bus.mem_en_o && first_addr == '1)
        first_addr = bus.mem_addr_o;
      if (bus.dm_done_o) begin
        t_dm = i; bus.dm_rd_i = 0;
      end
      if (bus.if_valid_o) begin
        t_if = i; bus.if_req_i = 0;
      end
    end
    chk("cont_first", 32'(first_addr), 32'h40);
    chk("cont_dm_at", 32'(t_dm), 32'(W + 1));
    chk("cont_gap", 32'(t_if - t_dm), 32'(W));
    repeat (2) cyc();

    // fairness under continuous data traffic
    bus.if_req_i = 1; bus.if_addr_i = 18'h00100;
    bus.dm_rd_i = 1; bus.dm_addr_i = 18'h00200;
    seen = 0; t0 = 0;
    for (int i = 1; i < 4 * W + 4 && !seen; i++) begin
      bus.mem_rdata_i = 16'($urandom);
      cyc();
      if (bus.dm_done_o)
        bus.dm_addr_i = bus.dm_addr_i + 1;
      if (bus.if_valid_o) begin
        seen = 1; t0 = i;
        bus.if_addr_i = bus.if_addr_i + 1;
      end
    end
    chk("fair_latency",
        32'(seen && t0 <= 2 * W + 1), 1);
    prev = 1; alt_ok = 1; npulse = 0;
    for (int i = 0; i < 24; i++) begin
      bus.mem_rdata_i = 16'($urandom);
      cyc();
      if (bus.if_valid_o) begin
        if (prev == 1) alt_ok = 0;
        prev = 1; npulse++;
        bus.if_addr_i = bus.if_addr_i + 1;
      end
      if (bus.dm_done_o) begin
        if (prev == 2) alt_ok = 0;
        prev = 2; npulse++;
        bus.dm_addr_i = bus.dm_addr_i + 1;
      end
    end
    chk("fair_alt", 32'(alt_ok), 1);
    chk("fair_count", 32'(npulse >= 8), 1);
    idle_inputs();
    repeat (3) cyc();

    // reset in the second access cycle
    bus.dm_rd_i = 1; bus.dm_addr_i = 18'h00050;
    cyc();
    chk("mr_en1", 32'(bus.mem_en_o), 1);
    cyc();
    chk("mr_en2", 32'(bus.mem_en_o), 1);
    rst = 1; bus.dm_rd_i = 0;
    cyc();
    chk("mr_en_drop", 32'(bus.mem_en_o), 0);
    chk("mr_no_done", 32'(bus.dm_done_o), 0);
    rst = 0;
    cyc();
    chk("mr_no_done2", 32'(bus.dm_done_o), 0);
    chk("mr_ifr", 32'(bus.if_rdata_o), 32'h0800);
    chk("mr_dmr", 32'(bus.dm_rdata_o), 0);

    // randomized traffic
    perr_now = 0;
    for (int i = 0; i < 3000; i++) begin
      if (perr_now) begin
        bus.dm_rd_i = 0; bus.dm_wr_i = 0;
        perr_now = 0;
      end
      if (m_ifv) begin
        if ($urandom_range(1) == 1)
          bus.if_addr_i = 18'($urandom);
        else
          bus.if_req_i = 0;
      end else if (!bus.if_req_i &&
                   $urandom_range(3) == 0) begin
        bus.if_req_i = 1;
        bus.if_addr_i = 18'($urandom);
      end
      if (m_dmd) begin
        if ($urandom_range(1) == 1) dm_new_op();
        else begin
          bus.dm_rd_i = 0; bus.dm_wr_i = 0;
        end
      end else if (!(bus.dm_rd_i ^ bus.dm_wr_i))
      begin
        cnt = int'($urandom_range(15));
        if (cnt == 0) begin
          bus.dm_rd_i = 1; bus.dm_wr_i = 1;
          perr_now = 1;
        end else if (cnt < 5) begin
          dm_new_op();
        end
      end
      bus.mem_rdata_i = 16'($urandom);
      rst = ($urandom_range(199) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
